// File: rtl/route_compute_pipe.sv
// rtl/route_compute_pipe.sv - registered, handshaked route-compute stage with retry/backoff
// Optional reroute path is enabled by defining ROUTE_ADAPTIVE_EN.
module route_compute_pipe #(
   parameter int TILE_BITS = 2,
   parameter int LOCAL_BITS = 2,
   parameter int VC_BITS = 2,
   parameter logic [(2**VC_BITS)-1:0] SER_VC_MASK = 4'b0010,
   parameter int MAX_RETRY = 3,
   parameter int BACKOFF_BASE = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [TILE_BITS-1:0]  cur_x,
   input  logic [TILE_BITS-1:0]  cur_y,
   input  logic [LOCAL_BITS-1:0] cur_lx,
   input  logic [LOCAL_BITS-1:0] cur_ly,
   input  logic [TILE_BITS-1:0]  dst_x,
   input  logic [TILE_BITS-1:0]  dst_y,
   input  logic [LOCAL_BITS-1:0] dst_lx,
   input  logic [LOCAL_BITS-1:0] dst_ly,
   input  logic [VC_BITS-1:0]    vc_class,
   input  logic [11:0]           link_up,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [11:0]           out_port,
   output logic                  out_eject,
   output logic                  out_rerouted,
   output logic                  drop_pulse,
   output logic [15:0]           drop_cnt,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, EVAL, HOLD, BACKOFF} state_t;

   state_t                state_q;
   logic [TILE_BITS-1:0]  dst_x_q, dst_y_q;
   logic [LOCAL_BITS-1:0] dst_lx_q, dst_ly_q;
   logic [VC_BITS-1:0]    vc_q;
   logic [2:0]            retry_q;
   logic [15:0]           backoff_q;
   logic                  out_valid_q, out_eject_q, out_rerouted_q, drop_pulse_q;
   logic [11:0]           out_port_q;
   logic [15:0]           drop_cnt_q;

   logic        tile_same, local_same, go_n, go_s, go_e, go_w, diag;
   logic [1:0]  dir;
   logic [3:0]  base;
   logic [11:0] vc_mask, allowed, primary_d, primary_ok_d, reroute_d;
`ifdef ROUTE_ADAPTIVE_EN
   logic [1:0]  cand;
`endif

   function automatic logic [11:0] onehot(input logic [3:0] idx);
      onehot = 12'd1 << idx;
   endfunction

   // dir: 0=N 1=S 2=E 3=W; base selects the plain ports (0) or SerDes ports (8)
   always_comb begin
      tile_same  = (dst_x_q == cur_x) && (dst_y_q == cur_y);
      local_same = (dst_lx_q == cur_lx) && (dst_ly_q == cur_ly);
      if (tile_same) begin
         go_n = dst_ly_q > cur_ly;
         go_s = dst_ly_q < cur_ly;
         go_e = dst_lx_q > cur_lx;
         go_w = dst_lx_q < cur_lx;
      end else begin
         go_n = dst_y_q > cur_y;
         go_s = dst_y_q < cur_y;
         go_e = dst_x_q > cur_x;
         go_w = dst_x_q < cur_x;
      end
      diag = tile_same && (go_n || go_s) && (go_e || go_w);
      if (go_n)      dir = 2'd0;
      else if (go_s) dir = 2'd1;
      else if (go_e) dir = 2'd2;
      else           dir = 2'd3;
      base = tile_same ? 4'd0 : 4'd8;
      if (diag) primary_d = onehot({2'b01, go_s, go_w});
      else      primary_d = onehot(base + {2'b00, dir});
      vc_mask = 12'hFFF;
      if (SER_VC_MASK[vc_q]) vc_mask[11:8] = 4'h0;
      allowed      = link_up & vc_mask;
      primary_ok_d = primary_d & allowed;
      reroute_d    = '0;
`ifdef ROUTE_ADAPTIVE_EN
      // Vertical blockage tries E,W then opposite; horizontal tries N,S then opposite.
      for (int k = 0; k < 3; k++) begin
         if (k == 0)      cand = {~dir[1], 1'b0};
         else if (k == 1) cand = {~dir[1], 1'b1};
         else             cand = dir ^ 2'b01;
         if (reroute_d == '0) reroute_d = onehot(base + {2'b00, cand}) & allowed;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         dst_x_q        <= '0;
         dst_y_q        <= '0;
         dst_lx_q       <= '0;
         dst_ly_q       <= '0;
         vc_q           <= '0;
         retry_q        <= '0;
         backoff_q      <= '0;
         out_valid_q    <= 1'b0;
         out_port_q     <= '0;
         out_eject_q    <= 1'b0;
         out_rerouted_q <= 1'b0;
         drop_pulse_q   <= 1'b0;
         drop_cnt_q     <= '0;
      end else begin
         drop_pulse_q <= 1'b0;
         case (state_q)
            IDLE: if (in_valid) begin
               dst_x_q  <= dst_x;
               dst_y_q  <= dst_y;
               dst_lx_q <= dst_lx;
               dst_ly_q <= dst_ly;
               vc_q     <= vc_class;
               retry_q  <= '0;
               state_q  <= EVAL;
            end
            EVAL: begin
               if (tile_same && local_same) begin
                  out_eject_q    <= 1'b1;
                  out_port_q     <= '0;
                  out_rerouted_q <= 1'b0;
                  out_valid_q    <= 1'b1;
                  state_q        <= HOLD;
               end else if (primary_ok_d != '0) begin
                  out_port_q     <= primary_ok_d;
                  out_rerouted_q <= 1'b0;
                  out_valid_q    <= 1'b1;
                  state_q        <= HOLD;
               end else if (reroute_d != '0) begin
                  out_port_q     <= reroute_d;
                  out_rerouted_q <= 1'b1;
                  out_valid_q    <= 1'b1;
                  state_q        <= HOLD;
               end else if (retry_q == 3'(MAX_RETRY - 1)) begin
                  drop_pulse_q <= 1'b1;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                  state_q <= IDLE;
               end else begin
                  retry_q   <= retry_q + 3'd1;
                  backoff_q <= 16'(BACKOFF_BASE) << retry_q;
                  state_q   <= BACKOFF;
               end
            end
            BACKOFF: begin
               if (backoff_q <= 16'd1) state_q <= EVAL;
               else                    backoff_q <= backoff_q - 16'd1;
            end
            HOLD: if (out_ready) begin
               out_valid_q    <= 1'b0;
               out_port_q     <= '0;
               out_eject_q    <= 1'b0;
               out_rerouted_q <= 1'b0;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign out_valid    = out_valid_q;
   assign out_port     = out_port_q;
   assign out_eject    = out_eject_q;
   assign out_rerouted = out_rerouted_q;
   assign drop_pulse   = drop_pulse_q;
   assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_route_compute_pipe.sv
// tb/tb_route_compute_pipe.sv - directed self-checking bench for route_compute_pipe
module tb_route_compute_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  cur_x, cur_y, cur_lx, cur_ly;
   logic [1:0]  dst_x, dst_y, dst_lx, dst_ly;
   logic [1:0]  vc_class;
   logic [11:0] link_up;
   logic        out_valid, out_ready;
   logic [11:0] out_port;
   logic        out_eject, out_rerouted, drop_pulse, busy;
   logic [15:0] drop_cnt;

   int errs = 0;
   int checks = 0;
   int lat;
   int got_drop;
   int raise_at = -1;
   int exp_drops = 0;
   int seen;

   route_compute_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .cur_x(cur_x), .cur_y(cur_y), .cur_lx(cur_lx), .cur_ly(cur_ly),
      .dst_x(dst_x), .dst_y(dst_y), .dst_lx(dst_lx), .dst_ly(dst_ly),
      .vc_class(vc_class), .link_up(link_up),
      .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
      .out_eject(out_eject), .out_rerouted(out_rerouted),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Accepting edge counts as edge 1; returns at the negedge after it.
   task automatic send(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] dlx,
                       input logic [1:0] dly, input logic [1:0] vc);
      @(negedge clk);
      dst_x = dx; dst_y = dy; dst_lx = dlx; dst_ly = dly; vc_class = vc;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      got_drop = 0;
   endtask

   task automatic run(input int limit);
      while (!out_valid && !got_drop && lat < limit) begin
         if (lat == raise_at) link_up = 12'hFFF;
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (drop_pulse) got_drop = 1;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_in_ready", in_ready, 1);
      check("hs_out_valid", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cur_x = 2'd1; cur_y = 2'd1; cur_lx = 2'd0; cur_ly = 2'd0;
      dst_x = '0; dst_y = '0; dst_lx = '0; dst_ly = '0; vc_class = '0;
      link_up = 12'hFFF;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_port", out_port, 0);
      check("rst_busy", busy, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_flags", {out_eject, out_rerouted, drop_pulse}, 0);
      rst = 1'b0;

      // Inter-tile east, all links up
      send(2'd3, 2'd1, 2'd0, 2'd0, 2'd0);
      check("t1_in_ready_eval", in_ready, 0);
      run(40);
      check("t1_lat", lat, 2);
      check("t1_port", out_port, 12'h400);
      check("t1_rerouted", out_rerouted, 0);
      check("t1_eject", out_eject, 0);
      check("t1_busy", busy, 1);
      link_up = 12'h000;
      @(posedge clk); @(negedge clk);
      check("t1_hold_port", out_port, 12'h400);
      check("t1_hold_valid", out_valid, 1);
      consume();
      link_up = 12'hFFF;

      // SER_E down
      link_up = 12'hBFF;
      send(2'd3, 2'd1, 2'd0, 2'd0, 2'd0);
      run(40);
`ifdef ROUTE_ADAPTIVE_EN
      check("t2_lat", lat, 2);
      check("t2_port", out_port, 12'h100);
      check("t2_rerouted", out_rerouted, 1);
      consume();
`else
      check("t2_drop", got_drop, 1);
      check("t2_lat", lat, 10);
      exp_drops++;
      check("t2_drop_cnt", drop_cnt, exp_drops);
`endif
      link_up = 12'hFFF;

      // VC class 1 may not use SerDes -> drop
      send(2'd3, 2'd1, 2'd0, 2'd0, 2'd1);
      run(40);
      check("t3_drop", got_drop, 1);
      check("t3_lat", lat, 10);
      check("t3_no_valid", out_valid, 0);
      exp_drops++;
      check("t3_drop_cnt", drop_cnt, exp_drops);
      @(posedge clk); @(negedge clk);
      check("t3_pulse_len", drop_pulse, 0);

      // Local delivery with allocator stall
      send(2'd1, 2'd1, 2'd0, 2'd0, 2'd0);
      run(40);
      check("t4_lat", lat, 2);
      for (int i = 0; i < 5; i++) begin
         check("t4_valid", out_valid, 1);
         check("t4_eject", out_eject, 1);
         check("t4_port", out_port, 0);
         check("t4_in_ready", in_ready, 0);
         link_up = link_up ^ 12'h0F0;
         @(posedge clk); @(negedge clk);
      end
      link_up = 12'hFFF;
      consume();

      // N beats E for inter-tile; intra-tile diagonal and axis
      send(2'd2, 2'd3, 2'd0, 2'd0, 2'd0);
      run(40);
      check("t5_n_port", out_port, 12'h100);
      consume();
      send(2'd1, 2'd1, 2'd1, 2'd1, 2'd1);
      run(40);
      check("t5_ne_port", out_port, 12'h010);
      consume();
      send(2'd1, 2'd1, 2'd0, 2'd2, 2'd0);
      run(40);
      check("t5_axis_port", out_port, 12'h001);
      consume();

      // Links come up during the second backoff
      link_up = 12'h000;
      raise_at = 6;
      send(2'd3, 2'd1, 2'd0, 2'd0, 2'd0);
      run(40);
      raise_at = -1;
      check("t6_drop", got_drop, 0);
      check("t6_lat", lat, 10);
      check("t6_port", out_port, 12'h400);
      check("t6_rerouted", out_rerouted, 0);
      consume();

      // Reset during backoff aborts silently
      link_up = 12'h000;
      send(2'd3, 2'd1, 2'd0, 2'd0, 2'd0);
      run(3);
      check("t7_busy_pre", busy, 1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("t7_in_ready", in_ready, 1);
      check("t7_outs", {out_valid, out_port, out_eject, out_rerouted, drop_pulse, busy}, 0);
      check("t7_drop_cnt", drop_cnt, 0);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk); @(negedge clk);
         if (drop_pulse) seen = 1;
      end
      check("t7_no_drop", seen, 0);
      check("t7_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
